// File: rtl/fetch_stage_if.sv
// Instruction-memory read port of the fetch stage: one outstanding read,
// completed by inst_ready in the cycle the word is returned.
interface fetch_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;

    // Fetch stage side: issues the request, consumes the returned word.
    modport master (
        output inst_req,
        output inst_addr,
        input  inst_rdata,
        input  inst_ready
    );

    // Memory side: sees the request, returns the word.
    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_rdata,
        output inst_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: program counter, single-outstanding
// instruction-memory read, IF/ID pipeline register, stall/flush handling and
// delay-slot redirects from decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_f,
    input  logic                 flush_d,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    input  logic                 jump,
    input  logic [25:0]          jump_index,
    fetch_stage_if.master        imem,
    output logic [31:0]          instr_d,
    output logic [31:0]          pc_d,
    output logic [31:0]          pc_plus4_d,
    output logic                 valid_d,
    output logic                 adel_d,
    output logic                 fetch_busy
);

    // RUN: a read is issued from pc_f. HOLD: the word came back while the
    // pipeline was stalled and sits in the hold buffer; no read is issued.
    typedef enum logic {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc_f;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;

    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic        r_hold_adel;

    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;
    logic        r_adel_d;

    logic        w_misaligned;
    logic        w_fetch_done;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_word;
    logic        w_redirect;
    logic [31:0] w_redirect_target;
    logic [31:0] w_next_pc;

    logic        w_inst_req;
    logic        w_pc_advance;
    logic        w_ifid_load_fetch;
    logic        w_ifid_load_hold;
    logic        w_ifid_bubble;
    logic        w_hold_capture;

    // A misaligned PC never reaches memory; it completes at once as an
    // address-error word so the exception travels down the pipe with its PC.
    assign w_misaligned  = (r_pc_f[1:0] != 2'b00);
    assign w_fetch_done  = (r_state == S_RUN) && (imem.inst_ready || w_misaligned);
    assign w_pc_plus4    = r_pc_f + 32'd4;
    assign w_word        = w_misaligned ? 32'd0 : imem.inst_rdata;

    // Branch wins over jump; the jump region comes from the delay-slot PC.
    assign w_redirect        = branch_taken || jump;
    assign w_redirect_target = branch_taken ? branch_target
                                            : {r_pc_plus4_d[31:28], jump_index, 2'b00};
    assign w_next_pc         = w_redirect   ? w_redirect_target :
                               r_pend_valid ? r_pend_target     : w_pc_plus4;

    // State register of the fetch FSM.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_next;
    end

    // Next-state logic: park a word returned under stall, release when unstalled.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        w_state_next = r_state;
        case (r_state)
            S_RUN:   if (w_fetch_done && stall_f) w_state_next = S_HOLD;
            S_HOLD:  if (!stall_f)                w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    // Output logic: memory request and the IF/ID / hold-buffer load strobes.
    always_comb begin
        w_inst_req        = 1'b0;
        w_pc_advance      = 1'b0;
        w_ifid_load_fetch = 1'b0;
        w_ifid_load_hold  = 1'b0;
        w_ifid_bubble     = 1'b0;
        w_hold_capture    = 1'b0;
        case (r_state)
            S_RUN: begin
                w_inst_req        = !rst && !w_misaligned;
                w_pc_advance      = w_fetch_done;
                w_ifid_load_fetch = w_fetch_done && !stall_f;
                w_hold_capture    = w_fetch_done && stall_f;
                w_ifid_bubble     = !w_fetch_done && !stall_f;
            end
            S_HOLD: begin
                w_ifid_load_hold  = !stall_f;
            end
            default: ;
        endcase
    end

    // Program counter and pending redirect: a redirect that arrives before the
    // current read completes is remembered and applied when it does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_f        <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
        end else if (w_pc_advance) begin
            r_pc_f        <= w_next_pc;
            r_pend_valid  <= 1'b0;
        end else if (w_redirect) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= w_redirect_target;
        end
    end

    // Hold buffer: keeps a word (with its PC and error flag) returned while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 32'd0;
            r_hold_adel  <= 1'b0;
        end else if (w_hold_capture) begin
            r_hold_instr <= w_word;
            r_hold_pc    <= r_pc_f;
            r_hold_adel  <= w_misaligned;
        end
    end

    // IF/ID register: flush beats everything, then fetch/hold loads, then bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_d) begin
            r_instr_d    <= 32'd0;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
            r_adel_d     <= 1'b0;
        end else if (w_ifid_load_fetch) begin
            r_instr_d    <= w_word;
            r_pc_d       <= r_pc_f;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
            r_adel_d     <= w_misaligned;
        end else if (w_ifid_load_hold) begin
            r_instr_d    <= r_hold_instr;
            r_pc_d       <= r_hold_pc;
            r_pc_plus4_d <= r_hold_pc + 32'd4;
            r_valid_d    <= 1'b1;
            r_adel_d     <= r_hold_adel;
        end else if (w_ifid_bubble) begin
            r_instr_d    <= 32'd0;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
            r_adel_d     <= 1'b0;
        end
    end

    assign imem.inst_req  = w_inst_req;
    assign imem.inst_addr = r_pc_f;
    assign fetch_busy     = w_inst_req && !imem.inst_ready;

    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;
    assign valid_d    = r_valid_d;
    assign adel_d     = r_adel_d;

endmodule
